voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Shares the two tone channels among the 48 keyboard keys during live play; the channels are PWM music generators 1 and 2, driven by 6-bit key codes.
- Tracks key press and release edges, assigns each new press to a free channel, and steals the oldest channel when both are busy.
- Outputs feed the existing key-to-frequency decode stage and the recorder as arbiter1/arbiter2.
- During playback (play=1) the block flushes its channels and outputs silence.

Parameters:
- NUM_KEYS, 48, number of key request lines.
- CODE_W, 6, key code width. Code 0 = silent; codes 1..48 = key index + 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- keys  input  NUM_KEYS  key levels; bit i is key i held.
- play  input  1  playback active; flush channels and ignore keys.
- poly_en  input  1  1 = two-channel polyphonic, 0 = mono on channel 1 only.
- arbiter1  output  CODE_W  channel 1 key code.
- arbiter2  output  CODE_W  channel 2 key code.
- voice_busy  output  2  bit v = channel v+1 holds a key.
- steal_pulse  output  1  one-cycle pulse when a held channel is reassigned.

Behaviour:
- Reset (synchronous): arbiter1=0, arbiter2=0, voice_busy=0, steal_pulse=0. Also clears keys_s, keys_d, pending and oldest.
- Input sampling:
  - keys_s <= keys; keys_d <= keys_s.
  - rise = keys_s & ~keys_d; fall = ~keys_s & keys_d.
- Pending vector: pend <= (pend | rise) & ~fall & ~grant_onehot. A released key is never allocated.
- Candidate: the lowest index set in (pend | rise). At most one grant per cycle; any other presses wait in pend.
- Latency: a key high at edge N appears on arbiterX after edge N+2 if no lower-index request is waiting. Each extra waiting lower-index request adds 1 cycle.
- Per-cycle order, evaluated on the same state, all in one edge:
  - Step 1, release: any channel whose key is in fall goes to code 0 and busy 0.
  - Step 2, allocate the candidate:
    - If a channel is free after step 1, use the lowest-numbered free channel.
    - Otherwise steal the channel pointed to by oldest and pulse steal_pulse. The stolen key is dropped, not re-queued.
- Oldest pointer (1 bit):
  - On assignment to channel v while the other channel is busy: oldest <= other channel.
  - On assignment when the other channel is idle: oldest <= v.
  - On release of one channel: oldest <= the remaining busy channel.
  - Both channels idle: oldest=0.
- A re-press of a key already held by a channel requires a release first. A release and re-press in consecutive samples reallocate normally.
- Mono mode (poly_en=0):
  - Channel 2 is forced idle (arbiter2=0).
  - Each grant overwrites channel 1 (last-note priority); steal_pulse asserts only if channel 1 was busy with a different key.
  - Releasing the channel 1 key silences it and does not resume an older held key.
- poly_en falling while channel 2 is busy: channel 2 is cleared on the next edge and oldest is set to 0.
- play=1: on each edge arbiterX=0, busy=0, pend=0, oldest=0; keys_s and keys_d keep sampling. On play falling, keys already held do not re-trigger (no rise).
- steal_pulse is high only in the cycle after a steal edge, otherwise 0.
- Keys outside 0..NUM_KEYS-1 do not exist. Code arithmetic is index+1 at CODE_W bits.

Decomposition:
- Shared package:
  - CODE_SILENT=0.
  - Constants NUM_KEYS=48 and CODE_W=6.
  - A function key_to_code(index).
- One sub-module is natural: prio_enc48, a combinational lowest-set-bit encoder, 48 inputs to a 6-bit index plus a valid bit. Instantiate it once for the candidate.
- Channel state and the oldest pointer stay in the top module.

Test Plan:
- Reset: hold reset 3 cycles with keys=all ones -> arbiter1=arbiter2=0, voice_busy=0. After release and no key edges, outputs stay 0.
- Single key: press key 9 at edge N -> arbiter1=10 after edge N+2, voice_busy=01. Release key 9 -> arbiter1=0 two edges after the release is sampled.
- Simultaneous presses: keys 3 and 20 rise in the same cycle -> arbiter1=4 at N+2, arbiter2=21 at N+3, steal_pulse never asserts.
- Steal: hold keys 3 and 20 (oldest=channel 1), then press key 40 -> arbiter1=41, arbiter2=21, steal_pulse high for exactly 1 cycle, oldest=channel 2. Releasing key 3 afterwards changes nothing.
- Release plus press in the same cycle: both channels busy, key 20 falls while key 5 rises -> channel 2 becomes code 6, no steal_pulse.
- Mono and play:
  - poly_en=0, press 1 then 2 -> arbiter1=3, arbiter2=0, one steal_pulse.
  - Assert play -> all outputs 0 the next edge.
  - Deassert play with keys still held -> no reallocation.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared types, constants and key/code helpers for the two-channel voice allocator.
package voice_allocator_pkg;

    localparam int NUM_KEYS = 48;
    localparam int CODE_W   = 6;
    localparam int IDX_W    = 6;
    localparam logic [CODE_W-1:0] CODE_SILENT = '0;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    typedef struct packed {
        logic              busy;
        logic [CODE_W-1:0] code;
    } chan_t;

    function automatic logic [CODE_W-1:0] key_to_code(input logic [IDX_W-1:0] index);
        return index + CODE_W'(1);
    endfunction

    // Only meaningful for a busy channel; code 0 has no key.
    function automatic logic [IDX_W-1:0] code_to_key(input logic [CODE_W-1:0] code);
        return code - CODE_W'(1);
    endfunction

endpackage

// File: rtl/voice_allocator_prio_enc48.sv
// Combinational lowest-set-bit encoder: 48 request lines to a 6-bit index plus valid.
module prio_enc48
    import voice_allocator_pkg::*;
(
    input  logic [NUM_KEYS-1:0] req,
    output logic [IDX_W-1:0]    index,
    output logic                valid
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        index = '0;
        valid = 1'b0;
        // Scanning downward lets the lowest set bit win by being written last.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Shares two tone channels among 48 keys: edge detection, pending queue, free-channel
// allocation with oldest-channel stealing, mono mode and playback flush.
module voice_allocator
    import voice_allocator_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                play,
    input  logic                poly_en,
    output logic [CODE_W-1:0]   arbiter1,
    output logic [CODE_W-1:0]   arbiter2,
    output logic [1:0]          voice_busy,
    output logic                steal_pulse
);

    key_vec_t         keys_s, keys_d, pend;
    key_vec_t         rise, fall, req, grant_onehot, pend_d;
    chan_t [1:0]      chan_q, chan_d;
    logic             oldest_q, oldest_d;
    logic             steal_d;
    logic             assign_ch;
    logic [1:0]       busy_rel;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_valid;

    assign rise = keys_s & ~keys_d;
    assign fall = ~keys_s & keys_d;
    // A key released this cycle must never win, even if it is still pending.
    assign req  = (pend | rise) & ~fall;

    prio_enc48 u_cand (
        .req   (req),
        .index (cand_idx),
        .valid (cand_valid)
    );

    always_comb begin
        grant_onehot = cand_valid ? (key_vec_t'(1) << cand_idx) : '0;
        pend_d       = req & ~grant_onehot;
        chan_d       = chan_q;
        oldest_d     = oldest_q;
        steal_d      = 1'b0;
        assign_ch    = 1'b0;

        // Releases are applied before allocation so a freed channel is reusable this cycle.
        for (int v = 0; v < 2; v++) begin
            if (chan_q[v].busy && fall[code_to_key(chan_q[v].code)]) begin
                chan_d[v] = '0;
            end
        end
        if (!poly_en) begin
            chan_d[1] = '0;
        end
        busy_rel = {chan_d[1].busy, chan_d[0].busy};

        if (cand_valid) begin
            if (!poly_en) begin
                steal_d = chan_d[0].busy && (chan_d[0].code != key_to_code(cand_idx));
            end else if (!busy_rel[0]) begin
                assign_ch = 1'b0;
            end else if (!busy_rel[1]) begin
                assign_ch = 1'b1;
            end else begin
                assign_ch = oldest_q;
                steal_d   = 1'b1;
            end
            chan_d[assign_ch] = '{busy: 1'b1, code: key_to_code(cand_idx)};
            oldest_d          = busy_rel[~assign_ch] ? ~assign_ch : assign_ch;
        end else begin
            case (busy_rel)
                2'b10:   oldest_d = 1'b1;
                2'b11:   oldest_d = oldest_q;
                default: oldest_d = 1'b0;
            endcase
        end

        if (play) begin
            chan_d   = '0;
            pend_d   = '0;
            oldest_d = 1'b0;
            steal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            keys_s      <= '0;
            keys_d      <= '0;
            pend        <= '0;
            chan_q      <= '0;
            oldest_q    <= 1'b0;
            steal_pulse <= 1'b0;
        end else begin
            // Sampling continues during playback so held keys show no rise afterwards.
            keys_s      <= keys;
            keys_d      <= keys_s;
            pend        <= pend_d;
            chan_q      <= chan_d;
            oldest_q    <= oldest_d;
            steal_pulse <= steal_d;
        end
    end

    assign arbiter1   = chan_q[0].code;
    assign arbiter2   = chan_q[1].code;
    assign voice_busy = {chan_q[1].busy, chan_q[0].busy};

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench: directed scenarios plus random key traffic against a timestamp-based model.
module tb_voice_allocator;

    localparam int NK = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] keys;
    logic          play;
    logic          poly_en;
    logic [5:0]    arbiter1, arbiter2;
    logic [1:0]    voice_busy;
    logic          steal_pulse;

    int n_vectors     = 0;
    int n_miscompares = 0;

    voice_allocator dut (
        .clk         (clk),
        .reset       (reset),
        .keys        (keys),
        .play        (play),
        .poly_en     (poly_en),
        .arbiter1    (arbiter1),
        .arbiter2    (arbiter2),
        .voice_busy  (voice_busy),
        .steal_pulse (steal_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: channels hold a key index (-1 idle) and the time it was assigned;
    // the channel with the earlier assignment time is the one to steal.
    logic [NK-1:0] m_last  = '0;
    logic [NK-1:0] m_prev  = '0;
    bit            m_pend[NK];
    int            m_ch[2] = '{-1, -1};
    int            m_t[2]  = '{0, 0};
    bit            m_steal = 1'b0;
    int            m_now   = 0;

    task automatic model_step();
        bit pressed[NK];
        bit released[NK];
        int cand;
        int v;
        m_now++;
        if (reset) begin
            m_last = '0; m_prev = '0; m_ch = '{-1, -1}; m_steal = 1'b0;
            for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
            return;
        end
        for (int i = 0; i < NK; i++) begin
            pressed[i]  = m_last[i] && !m_prev[i];
            released[i] = !m_last[i] && m_prev[i];
        end
        m_steal = 1'b0;
        if (play) begin
            m_ch = '{-1, -1};
            for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++)
                if (m_ch[c] >= 0 && released[m_ch[c]]) m_ch[c] = -1;
            if (!poly_en) m_ch[1] = -1;
            cand = -1;
            for (int i = 0; i < NK; i++) begin
                m_pend[i] = (m_pend[i] || pressed[i]) && !released[i];
                if (cand < 0 && m_pend[i]) cand = i;
            end
            if (cand >= 0) begin
                m_pend[cand] = 1'b0;
                if (!poly_en) begin
                    v = 0;
                    m_steal = (m_ch[0] >= 0) && (m_ch[0] != cand);
                end else if (m_ch[0] < 0) begin
                    v = 0;
                end else if (m_ch[1] < 0) begin
                    v = 1;
                end else begin
                    v = (m_t[0] < m_t[1]) ? 0 : 1;
                    m_steal = 1'b1;
                end
                m_ch[v] = cand;
                m_t[v]  = m_now;
            end
        end
        m_prev = m_last;
        m_last = keys;
    endtask

    function automatic int exp_code(input int c);
        return (m_ch[c] < 0) ? 0 : m_ch[c] + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model advances on the edge, outputs are compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_arbiter1", 32'(arbiter1), 32'(exp_code(0)));
        check("model_arbiter2", 32'(arbiter2), 32'(exp_code(1)));
        check("model_busy", 32'(voice_busy), 32'({exp_code(1) != 0, exp_code(0) != 0}));
        check("model_steal", 32'(steal_pulse), 32'(m_steal));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int steals;
        logic [63:0] mask;
        for (int i = 0; i < NK; i++) m_pend[i] = 1'b0;
        reset = 1'b1; keys = '1; play = 1'b0; poly_en = 1'b1;

        // Reset with every key held
        ticks(3);
        check("reset_a1", 32'(arbiter1), 0);
        check("reset_a2", 32'(arbiter2), 0);
        check("reset_busy", 32'(voice_busy), 0);
        keys = '0; reset = 1'b0;
        ticks(3);
        check("idle_a1", 32'(arbiter1), 0);
        check("idle_busy", 32'(voice_busy), 0);

        // Single key 9: visible two edges after it is driven
        keys[9] = 1'b1;
        tick();
        check("k9_lat1", 32'(arbiter1), 0);
        tick();
        check("k9_a1", 32'(arbiter1), 10);
        check("k9_busy", 32'(voice_busy), 1);
        keys[9] = 1'b0;
        tick();
        check("k9_hold", 32'(arbiter1), 10);
        tick();
        check("k9_rel", 32'(arbiter1), 0);

        // Simultaneous presses of keys 3 and 20
        keys[3] = 1'b1; keys[20] = 1'b1;
        steals = 0;
        tick(); steals += int'(steal_pulse);
        tick(); steals += int'(steal_pulse);
        check("sim_a1", 32'(arbiter1), 4);
        check("sim_a2_wait", 32'(arbiter2), 0);
        tick(); steals += int'(steal_pulse);
        check("sim_a2", 32'(arbiter2), 21);
        check("sim_nosteal", 32'(steals), 0);

        // Key 40 steals channel 1 (the oldest)
        keys[40] = 1'b1;
        ticks(2);
        check("steal_a1", 32'(arbiter1), 41);
        check("steal_a2", 32'(arbiter2), 21);
        check("steal_pulse", 32'(steal_pulse), 1);
        tick();
        check("steal_once", 32'(steal_pulse), 0);
        keys[3] = 1'b0;
        ticks(3);
        check("stolen_rel_a1", 32'(arbiter1), 41);
        check("stolen_rel_a2", 32'(arbiter2), 21);

        // Release of key 20 and press of key 5 in the same sample
        keys[20] = 1'b0; keys[5] = 1'b1;
        ticks(2);
        check("swap_a2", 32'(arbiter2), 6);
        check("swap_a1", 32'(arbiter1), 41);
        check("swap_nosteal", 32'(steal_pulse), 0);
        keys = '0;
        ticks(3);

        // Mono mode: last note wins on channel 1
        poly_en = 1'b0;
        keys[1] = 1'b1;
        ticks(2);
        check("mono_a1_first", 32'(arbiter1), 2);
        keys[2] = 1'b1;
        ticks(2);
        check("mono_a1", 32'(arbiter1), 3);
        check("mono_a2", 32'(arbiter2), 0);
        check("mono_steal", 32'(steal_pulse), 1);

        // Playback flush, then no re-trigger of held keys
        play = 1'b1;
        tick();
        check("play_a1", 32'(arbiter1), 0);
        check("play_busy", 32'(voice_busy), 0);
        tick();
        play = 1'b0;
        ticks(3);
        check("unplay_a1", 32'(arbiter1), 0);
        check("unplay_busy", 32'(voice_busy), 0);
        keys = '0; poly_en = 1'b1;
        ticks(3);

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                keys ^= mask[NK-1:0];
            end
            if (play) play = ($urandom_range(0, 7) != 0);
            else      play = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 199) == 0) poly_en = ~poly_en;
            reset = ($urandom_range(0, 699) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
